// File: rtl/l2_bus_arbiter_2port.sv
// Two-port round-robin arbiter between the I-cache and D-cache miss handlers and
// one shared L2 port. Ownership is held per transaction, with a beat cap for fairness.
module l2_bus_arbiter_2port #(
   parameter int MAX_BEATS = 8,
   parameter int AW        = 32,
   parameter int DW        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req_en,
   input  logic [1:0]    req_wr_en,
   input  logic [AW-1:0] req_addr_0,
   input  logic [AW-1:0] req_addr_1,
   input  logic [DW-1:0] req_wr_data_0,
   input  logic [DW-1:0] req_wr_data_1,
   output logic [1:0]    rd_granted,
   output logic [1:0]    wr_granted,
   output logic [1:0]    beat_ack,
   output logic [DW-1:0] rd_data,
   output logic          l2_mem_en,
   output logic          l2_mem_wr_en,
   output logic [AW-1:0] l2_mem_access_addr,
   output logic [DW-1:0] l2_mem_wr_data,
   input  logic [DW-1:0] l2_mem_rd_data,
   input  logic          l2_mem_ack
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BEATS);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic          last_owner_r;
   logic          last_owner_nxt_s;
   logic [CW-1:0] beat_cnt_r;
   logic [CW-1:0] beat_cnt_nxt_s;
   logic          owner_s;
   logic          ack_s;

   assign rd_data = l2_mem_rd_data;
   assign owner_s = (state_r == OWN1);
   assign ack_s   = l2_mem_ack & l2_mem_en;

   // Forward the owner's beat to L2 and route grants/acks back to it.
   always_comb begin
      rd_granted         = 2'b00;
      wr_granted         = 2'b00;
      beat_ack           = 2'b00;
      l2_mem_en          = 1'b0;
      l2_mem_wr_en       = 1'b0;
      l2_mem_access_addr = '0;
      l2_mem_wr_data     = '0;
      case (state_r)
         OWN0: begin
            l2_mem_en          = req_en[0];
            l2_mem_wr_en       = req_wr_en[0];
            l2_mem_access_addr = req_addr_0;
            l2_mem_wr_data     = req_wr_data_0;
            rd_granted         = {1'b0, req_en[0] & ~req_wr_en[0]};
            wr_granted         = {1'b0, req_en[0] & req_wr_en[0]};
            beat_ack           = {1'b0, req_en[0] & l2_mem_ack};
         end
         OWN1: begin
            l2_mem_en          = req_en[1];
            l2_mem_wr_en       = req_wr_en[1];
            l2_mem_access_addr = req_addr_1;
            l2_mem_wr_data     = req_wr_data_1;
            rd_granted         = {req_en[1] & ~req_wr_en[1], 1'b0};
            wr_granted         = {req_en[1] & req_wr_en[1], 1'b0};
            beat_ack           = {req_en[1] & l2_mem_ack, 1'b0};
         end
         default: begin
            rd_granted = 2'b00;
         end
      endcase
   end

   // Arbitration, beat counting and release decisions.
   always_comb begin
      state_nxt_s      = state_r;
      last_owner_nxt_s = last_owner_r;
      beat_cnt_nxt_s   = beat_cnt_r;
      case (state_r)
         IDLE: begin
            case (req_en)
               2'b01: begin
                  state_nxt_s      = OWN0;
                  last_owner_nxt_s = 1'b0;
                  beat_cnt_nxt_s   = '0;
               end
               2'b10: begin
                  state_nxt_s      = OWN1;
                  last_owner_nxt_s = 1'b1;
                  beat_cnt_nxt_s   = '0;
               end
               2'b11: begin
                  // Contention goes to the port that did not own the bus last.
                  state_nxt_s      = last_owner_r ? OWN0 : OWN1;
                  last_owner_nxt_s = ~last_owner_r;
                  beat_cnt_nxt_s   = '0;
               end
               default: begin
                  state_nxt_s = IDLE;
               end
            endcase
         end
         OWN0, OWN1: begin
            if (ack_s && (beat_cnt_r != MAX_CNT)) begin
               beat_cnt_nxt_s = beat_cnt_r + CW'(1);
            end else begin
               beat_cnt_nxt_s = beat_cnt_r;
            end
            if (!req_en[owner_s]) begin
               state_nxt_s = IDLE;
            end else if (ack_s && (beat_cnt_r == LAST_CNT) && req_en[~owner_s]) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State registers; port 0 wins the first contention after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         last_owner_r <= 1'b1;
         beat_cnt_r   <= '0;
      end else begin
         state_r      <= state_nxt_s;
         last_owner_r <= last_owner_nxt_s;
         beat_cnt_r   <= beat_cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_l2_bus_arbiter_2port.sv
// Directed self-checking bench for l2_bus_arbiter_2port (MAX_BEATS = 4).
module tb_l2_bus_arbiter_2port;

   logic        clk;
   logic        rst;
   logic [1:0]  req_en;
   logic [1:0]  req_wr_en;
   logic [31:0] req_addr_0;
   logic [31:0] req_addr_1;
   logic [31:0] req_wr_data_0;
   logic [31:0] req_wr_data_1;
   logic [1:0]  rd_granted;
   logic [1:0]  wr_granted;
   logic [1:0]  beat_ack;
   logic [31:0] rd_data;
   logic        l2_mem_en;
   logic        l2_mem_wr_en;
   logic [31:0] l2_mem_access_addr;
   logic [31:0] l2_mem_wr_data;
   logic [31:0] l2_mem_rd_data;
   logic        l2_mem_ack;

   int checks   = 0;
   int failures = 0;

   l2_bus_arbiter_2port #(.MAX_BEATS(4), .AW(32), .DW(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .req_en             (req_en),
      .req_wr_en          (req_wr_en),
      .req_addr_0         (req_addr_0),
      .req_addr_1         (req_addr_1),
      .req_wr_data_0      (req_wr_data_0),
      .req_wr_data_1      (req_wr_data_1),
      .rd_granted         (rd_granted),
      .wr_granted         (wr_granted),
      .beat_ack           (beat_ack),
      .rd_data            (rd_data),
      .l2_mem_en          (l2_mem_en),
      .l2_mem_wr_en       (l2_mem_wr_en),
      .l2_mem_access_addr (l2_mem_access_addr),
      .l2_mem_wr_data     (l2_mem_wr_data),
      .l2_mem_rd_data     (l2_mem_rd_data),
      .l2_mem_ack         (l2_mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then changed there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req_en = 2'b00;
      req_wr_en = 2'b00;
      req_addr_0 = 32'h0000_0000;
      req_addr_1 = 32'h0000_0000;
      req_wr_data_0 = 32'h0000_0000;
      req_wr_data_1 = 32'h0000_0000;
      l2_mem_rd_data = 32'h0000_0000;
      l2_mem_ack = 1'b0;

      // Reset state
      tick(); tick();
      #2;
      chk("rst_rd_gnt", {30'd0, rd_granted}, 32'd0);
      chk("rst_wr_gnt", {30'd0, wr_granted}, 32'd0);
      chk("rst_mem_en", {31'd0, l2_mem_en}, 32'd0);
      chk("rst_addr", l2_mem_access_addr, 32'h0000_0000);
      tick();
      rst = 1'b0;

      // Single read on port 1
      tick();
      req_en = 2'b10; req_addr_1 = 32'h0000_1A20; req_addr_0 = 32'h0000_0BAD;
      #2;
      chk("rd1_latency", {30'd0, rd_granted}, 32'd0);
      tick();
      #2;
      chk("rd1_gnt", {30'd0, rd_granted}, 32'h2);
      chk("rd1_mem_en", {31'd0, l2_mem_en}, 32'd1);
      chk("rd1_addr", l2_mem_access_addr, 32'h0000_1A20);
      chk("rd1_noack", {30'd0, beat_ack}, 32'd0);
      tick(); tick();
      l2_mem_ack = 1'b1; l2_mem_rd_data = 32'hDEAD_BEEF;
      #2;
      chk("rd1_ack", {30'd0, beat_ack}, 32'h2);
      chk("rd1_data", rd_data, 32'hDEAD_BEEF);
      tick();
      l2_mem_ack = 1'b0; req_en = 2'b00;
      #2;
      chk("rd1_drop_comb", {30'd0, rd_granted}, 32'd0);
      chk("rd1_drop_en", {31'd0, l2_mem_en}, 32'd0);
      tick();
      #2;
      chk("rd1_idle", {30'd0, rd_granted | wr_granted}, 32'd0);

      // Spurious ack while idle
      l2_mem_ack = 1'b1;
      #1;
      chk("spur_ack", {30'd0, beat_ack}, 32'd0);
      tick();
      l2_mem_ack = 1'b0;

      // Contention: last owner was port 1, so port 0 wins
      req_en = 2'b11; req_addr_0 = 32'h0000_0100;
      tick();
      #2;
      chk("cont_p0", {30'd0, rd_granted}, 32'h1);
      chk("cont_p0_addr", l2_mem_access_addr, 32'h0000_0100);
      tick();
      req_en = 2'b10;
      #2;
      chk("cont_p0_drop", {30'd0, rd_granted}, 32'd0);
      tick();
      #2;
      chk("cont_gap", {30'd0, rd_granted}, 32'd0);
      tick();
      #2;
      chk("cont_p1", {30'd0, rd_granted}, 32'h2);
      tick();
      req_en = 2'b00;
      tick();
      req_en = 2'b11;
      tick();
      #2;
      chk("cont_rr_p0", {30'd0, rd_granted}, 32'h1);
      tick();
      req_en = 2'b00;
      tick();
      req_en = 2'b11;
      tick();
      #2;
      chk("cont_rr_p1", {30'd0, rd_granted}, 32'h2);
      tick();
      req_en = 2'b00;
      tick();

      // Forced release after 4 beats while port 1 waits
      req_en = 2'b01;
      tick();
      req_en = 2'b11;
      l2_mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         l2_mem_rd_data = 32'h0000_A000 + 32'(i);
         #2;
         chk("frc_p0_ack", {30'd0, beat_ack}, 32'h1);
         tick();
      end
      l2_mem_ack = 1'b0;
      #2;
      chk("frc_released", {30'd0, rd_granted}, 32'd0);
      tick();
      #2;
      chk("frc_p1_gnt", {30'd0, rd_granted}, 32'h2);
      l2_mem_ack = 1'b1;
      #1;
      chk("frc_p1_ack", {30'd0, beat_ack}, 32'h2);
      tick();
      l2_mem_ack = 1'b0; req_en = 2'b01;
      #2;
      chk("frc_p1_drop", {30'd0, rd_granted}, 32'd0);
      tick();
      tick();
      #2;
      chk("frc_p0_regrant", {30'd0, rd_granted}, 32'h1);
      l2_mem_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("frc_p0_rest", {30'd0, beat_ack}, 32'h1);
         tick();
      end
      l2_mem_ack = 1'b0; req_en = 2'b00;
      tick();

      // Mixed write then read under one ownership on port 1
      req_en = 2'b10; req_wr_en = 2'b10;
      req_addr_1 = 32'h0000_0040; req_wr_data_1 = 32'h1234_5678;
      tick();
      #2;
      chk("mix_wr_gnt", {30'd0, wr_granted}, 32'h2);
      chk("mix_wr_rdgnt", {30'd0, rd_granted}, 32'd0);
      chk("mix_wr_en", {31'd0, l2_mem_wr_en}, 32'd1);
      chk("mix_wr_data", l2_mem_wr_data, 32'h1234_5678);
      chk("mix_wr_addr", l2_mem_access_addr, 32'h0000_0040);
      l2_mem_ack = 1'b1;
      #1;
      chk("mix_wr_ack", {30'd0, beat_ack}, 32'h2);
      tick();
      l2_mem_ack = 1'b0; req_wr_en = 2'b00; req_addr_1 = 32'h0000_0044;
      #2;
      chk("mix_rd_gnt", {30'd0, rd_granted}, 32'h2);
      chk("mix_rd_wrgnt", {30'd0, wr_granted}, 32'd0);
      chk("mix_rd_wr_en", {31'd0, l2_mem_wr_en}, 32'd0);
      chk("mix_nogap", {31'd0, l2_mem_en}, 32'd1);
      chk("mix_rd_addr", l2_mem_access_addr, 32'h0000_0044);
      l2_mem_ack = 1'b1; l2_mem_rd_data = 32'hCAFE_F00D;
      #1;
      chk("mix_rd_ack", {30'd0, beat_ack}, 32'h2);
      chk("mix_rd_data", rd_data, 32'hCAFE_F00D);
      tick();
      l2_mem_ack = 1'b0;

      // Reset mid-beat while port 1 owns the bus
      #2;
      chk("rmb_owned", {31'd0, l2_mem_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rmb_gnt", {30'd0, rd_granted | wr_granted}, 32'd0);
      chk("rmb_mem_en", {31'd0, l2_mem_en}, 32'd0);
      tick();
      rst = 1'b0; req_en = 2'b11;
      tick();
      #2;
      chk("rmb_first_p0", {30'd0, rd_granted}, 32'h1);
      req_en = 2'b00;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
